// File: rtl/hour_counter.sv
// Hour stage of the timekeeping chain: counts minute-rollover pulses 0-23,
// supports manual up/down setting, and drives registered 24 h / 12 h BCD digits.
module hour_counter #(
  parameter logic [4:0] RESET_HOUR = 5'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       signal,
  input  logic       manual_set,
  input  logic       mode_12h,
  output logic [4:0] hour,
  output logic [3:0] disp_tens,
  output logic [3:0] disp_ones,
  output logic       pm,
  output logic       signal_out
);

  localparam int          RESET_INT  = int'(RESET_HOUR);
  localparam logic [3:0]  RESET_TENS = 4'(RESET_INT / 10);
  localparam logic [3:0]  RESET_ONES = 4'(RESET_INT % 10);
  localparam logic        RESET_PM   = (RESET_HOUR >= 5'd12);

  logic [4:0] r_hour;
  logic       r_signal_out;
  logic [3:0] r_disp_tens;
  logic [3:0] r_disp_ones;
  logic       r_pm;

  logic [4:0] w_next_hour;
  logic       w_carry;
  logic [4:0] w_disp_val;
  logic [3:0] w_tens;
  logic [3:0] w_ones;

  // Out-of-range hours (24-31) recover to 0 going up and to 23 going down.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_next_hour = r_hour;
    w_carry     = 1'b0;
    if (manual_set) begin
      if (up) begin
        w_next_hour = (r_hour >= 5'd23) ? 5'd0 : r_hour + 5'd1;
      end else if (down) begin
        w_next_hour = (r_hour == 5'd0 || r_hour > 5'd23) ? 5'd23 : r_hour - 5'd1;
      end
    end else if (signal) begin
      if (r_hour == 5'd23) begin
        w_next_hour = 5'd0;
        w_carry     = 1'b1;
      end else if (r_hour > 5'd23) begin
        w_next_hour = 5'd0;
      end else begin
        w_next_hour = r_hour + 5'd1;
      end
    end
  end

  always_comb begin
    w_disp_val = r_hour;
    if (mode_12h) begin
      if (r_hour == 5'd0) begin
        w_disp_val = 5'd12;
      end else if (r_hour > 5'd12) begin
        w_disp_val = r_hour - 5'd12;
      end
    end
  end

  // Binary to two BCD digits; the value never exceeds 31.
  always_comb begin
    w_tens = 4'd0;
    w_ones = 4'(w_disp_val);
    if (w_disp_val >= 5'd30) begin
      w_tens = 4'd3;
      w_ones = 4'(w_disp_val - 5'd30);
    end else if (w_disp_val >= 5'd20) begin
      w_tens = 4'd2;
      w_ones = 4'(w_disp_val - 5'd20);
    end else if (w_disp_val >= 5'd10) begin
      w_tens = 4'd1;
      w_ones = 4'(w_disp_val - 5'd10);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hour       <= RESET_HOUR;
      r_signal_out <= 1'b0;
      r_disp_tens  <= RESET_TENS;
      r_disp_ones  <= RESET_ONES;
      r_pm         <= RESET_PM;
    end else begin
      // NOTE: non-blocking assignments so the display samples the pre-edge hour,
      // which gives it exactly one cycle of lag behind the count.
      r_hour       <= w_next_hour;
      r_signal_out <= w_carry;
      r_disp_tens  <= w_tens;
      r_disp_ones  <= w_ones;
      r_pm         <= (r_hour >= 5'd12);
    end
  end

  assign hour       = r_hour;
  assign signal_out = r_signal_out;
  assign disp_tens  = r_disp_tens;
  assign disp_ones  = r_disp_ones;
  assign pm         = r_pm;

endmodule

// File: tb/tb_hour_counter.sv
// Self-checking bench for hour_counter: directed sequences for reset, rollover,
// 12 h display and reset-during-carry, plus a table of manual-set vectors.
module tb_hour_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       up, down, signal, manual_set, mode_12h;
  logic [4:0] hour;
  logic [3:0] disp_tens, disp_ones;
  logic       pm, signal_out;

  int n_checks = 0;
  int n_fail   = 0;

  hour_counter dut (
    .clk        (clk),
    .rst        (rst),
    .up         (up),
    .down       (down),
    .signal     (signal),
    .manual_set (manual_set),
    .mode_12h   (mode_12h),
    .hour       (hour),
    .disp_tens  (disp_tens),
    .disp_ones  (disp_ones),
    .pm         (pm),
    .signal_out (signal_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ms;
    logic       up;
    logic       dn;
    logic       sig;
    logic [4:0] exp_hour;
    logic       exp_so;
  } vec_t;

  // Starts from hour 0; each record is applied for exactly one clock edge.
  localparam int NVEC = 24;
  vec_t vecs [NVEC] = '{
    '{1'b1, 1'b0, 1'b1, 1'b0, 5'd23, 1'b0},  // manual down wraps 0 -> 23, no carry
    '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0},  // manual up wraps 23 -> 0, no carry
    '{1'b1, 1'b1, 1'b0, 1'b0, 5'd1,  1'b0},
    '{1'b1, 1'b1, 1'b0, 1'b0, 5'd2,  1'b0},
    '{1'b1, 1'b1, 1'b0, 1'b0, 5'd3,  1'b0},
    '{1'b1, 1'b1, 1'b0, 1'b0, 5'd4,  1'b0},
    '{1'b1, 1'b1, 1'b0, 1'b0, 5'd5,  1'b0},
    '{1'b1, 1'b1, 1'b1, 1'b0, 5'd6,  1'b0},  // up and down together: up wins
    '{1'b1, 1'b0, 1'b1, 1'b0, 5'd5,  1'b0},
    '{1'b1, 1'b0, 1'b0, 1'b0, 5'd5,  1'b0},  // manual hold
    '{1'b0, 1'b1, 1'b0, 1'b0, 5'd5,  1'b0},  // up ignored outside manual mode
    '{1'b0, 1'b0, 1'b1, 1'b0, 5'd5,  1'b0},  // down ignored outside manual mode
    '{1'b0, 1'b0, 1'b0, 1'b1, 5'd6,  1'b0},
    '{1'b1, 1'b0, 1'b1, 1'b0, 5'd5,  1'b0},
    '{1'b1, 1'b0, 1'b1, 1'b0, 5'd4,  1'b0},
    '{1'b1, 1'b0, 1'b1, 1'b0, 5'd3,  1'b0},
    '{1'b1, 1'b0, 1'b1, 1'b1, 5'd2,  1'b0},  // signal discarded while setting
    '{1'b1, 1'b0, 1'b1, 1'b0, 5'd1,  1'b0},
    '{1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0},
    '{1'b1, 1'b0, 1'b1, 1'b0, 5'd23, 1'b0},
    '{1'b1, 1'b0, 1'b0, 1'b1, 5'd23, 1'b0},  // signal at 23 in manual mode: hold, no carry
    '{1'b1, 1'b1, 1'b0, 1'b1, 5'd0,  1'b0},  // manual wrap with signal present: no carry
    '{1'b1, 1'b0, 1'b1, 1'b0, 5'd23, 1'b0},
    '{1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  1'b1}   // signal-driven wrap: carry
  };

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hour(input logic [4:0] target);
    manual_set = 1'b1;
    up         = 1'b1;
    down       = 1'b0;
    for (int k = 0; k < 30 && hour != target; k++) tick();
    manual_set = 1'b0;
    up         = 1'b0;
    check("set_hour", 8'(hour), 8'(target));
  endtask

  task automatic check_disp(input string name, input logic [3:0] t,
                            input logic [3:0] o, input logic p);
    check({name, "_tens"}, 8'(disp_tens), 8'(t));
    check({name, "_ones"}, 8'(disp_ones), 8'(o));
    check({name, "_pm"},   8'(pm),        8'(p));
  endtask

  // Hand-computed 12 h sweep: hour, tens, ones, pm.
  logic [4:0] sweep_hour [6] = '{5'd0, 5'd1, 5'd11, 5'd12, 5'd13, 5'd23};
  logic [3:0] sweep_tens [6] = '{4'd1, 4'd0, 4'd1,  4'd1,  4'd0,  4'd1};
  logic [3:0] sweep_ones [6] = '{4'd2, 4'd1, 4'd1,  4'd2,  4'd1,  4'd1};
  logic       sweep_pm   [6] = '{1'b0, 1'b0, 1'b0,  1'b1,  1'b1,  1'b1};

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; up = 1'b0; down = 1'b0; signal = 1'b0;
    manual_set = 1'b0; mode_12h = 1'b0;

    // Reset state, then release mid-cycle with a signal already pending.
    repeat (2) tick();
    check("rst_hour", 8'(hour), 8'd0);
    check("rst_sigout", 8'(signal_out), 8'd0);
    check_disp("rst_disp", 4'd0, 4'd0, 1'b0);
    signal = 1'b1;
    #3 rst = 1'b0;
    #1 check("rst_release_hold", 8'(hour), 8'd0);
    tick();
    check("first_edge_count", 8'(hour), 8'd1);
    signal = 1'b0;
    rst = 1'b1;
    #2 check("async_rst_hour", 8'(hour), 8'd0);
    rst = 1'b0;

    // 24 back-to-back signal pulses: 0 -> 23 -> 0 with one carry.
    signal = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      check("roll_hour", 8'(hour), 8'(i % 24));
      check("roll_sigout", 8'(signal_out), 8'(i == 24));
      check("roll_pm", 8'(pm), 8'((i - 1) >= 12));
      check("roll_tens", 8'(disp_tens), 8'((i - 1) / 10));
      check("roll_ones", 8'(disp_ones), 8'((i - 1) % 10));
    end
    signal = 1'b0;
    tick();
    check("roll_sigout_clear", 8'(signal_out), 8'd0);
    check("roll_hold", 8'(hour), 8'd0);

    // Table of manual/ignored-input vectors.
    for (int v = 0; v < NVEC; v++) begin
      manual_set = vecs[v].ms;
      up         = vecs[v].up;
      down       = vecs[v].dn;
      signal     = vecs[v].sig;
      tick();
      check($sformatf("vec%0d_hour", v), 8'(hour), 8'(vecs[v].exp_hour));
      check($sformatf("vec%0d_sigout", v), 8'(signal_out), 8'(vecs[v].exp_so));
    end
    manual_set = 1'b0; up = 1'b0; down = 1'b0; signal = 1'b0;
    tick();

    // 12 h display sweep.
    mode_12h = 1'b1;
    for (int s = 0; s < 6; s++) begin
      set_hour(sweep_hour[s]);
      tick();
      check_disp($sformatf("h12_%0d", sweep_hour[s]), sweep_tens[s], sweep_ones[s], sweep_pm[s]);
    end

    // Switching to 24 h shows one cycle later without touching the count.
    mode_12h = 1'b0;
    #1 check_disp("mode_lag", 4'd1, 4'd1, 1'b1);
    tick();
    check_disp("mode_24h", 4'd2, 4'd3, 1'b1);
    check("mode_hour", 8'(hour), 8'd23);

    // Reset arriving while the carry pulse is pending.
    signal = 1'b1;
    tick();
    signal = 1'b0;
    check("carry_pre", 8'(signal_out), 8'd1);
    #2 rst = 1'b1;
    #1 check("carry_rst_sigout", 8'(signal_out), 8'd0);
    check("carry_rst_hour", 8'(hour), 8'd0);
    check_disp("carry_rst_disp", 4'd0, 4'd0, 1'b0);
    tick();
    check("carry_rst_held", 8'(signal_out), 8'd0);
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hour_counter.md
# hour_counter

Hour stage of the clock timekeeping chain, directly downstream of the minute counter. It consumes the minute stage's one-cycle rollover pulse and keeps a 0–23 hour count. It supports manual up/down setting and produces registered BCD display digits in 24 h or 12 h format with a PM flag. It emits a one-cycle carry pulse to the day stage on the 23→0 rollover.

## Interface
- `RESET_HOUR`, default 0: hour value loaded on reset; legal range 0–23.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `up` input 1: manual increment request; sampled only while `manual_set` = 1; one step per cycle high.
- `down` input 1: manual decrement request; same rules as `up`.
- `signal` input 1: one-cycle minute-rollover pulse from the minute stage.
- `manual_set` input 1: setting mode. When high, `up`/`down` act and `signal` is ignored.
- `mode_12h` input 1: display format; 0 = 24 h, 1 = 12 h.
- `hour` output 5: binary hour, 0–23.
- `disp_tens` output 4: BCD tens digit of the displayed hour.
- `disp_ones` output 4: BCD ones digit of the displayed hour.
- `pm` output 1: high when `hour` ≥ 12, in both display formats.
- `signal_out` output 1: one-cycle carry to the day stage.

## Operation
- Reset values:
  - `hour` = `RESET_HOUR`.
  - `signal_out` = 0.
  - `disp_tens`/`disp_ones`/`pm` = the 24 h encoding of `RESET_HOUR`. With the default: 0, 0, 0.
- Count update, evaluated every cycle in this priority order:
  1. `manual_set` = 1 and `up` = 1: `hour` = 0 if `hour` = 23, else `hour` + 1.
  2. `manual_set` = 1 and `down` = 1 (`up` = 0): `hour` = 23 if `hour` = 0, else `hour` − 1.
  3. `manual_set` = 1, neither `up` nor `down`: hold. A `signal` arriving in this cycle is discarded, not queued.
  4. `manual_set` = 0 and `signal` = 1: if `hour` = 23, then `hour` = 0 and `signal_out` = 1; else `hour` + 1.
  5. Otherwise: hold.
- `up` and `down` both high: `up` wins.
- `up`/`down` are ignored when `manual_set` = 0.
- `signal_out` defaults to 0 each cycle. It is asserted only by the `signal`-driven 23→0 wrap, never by a manual wrap.
- Arithmetic is 5-bit unsigned. `hour` never holds 24–31. If it does (fault injection), the next `signal` or `up` loads 0, and `down` loads 23.
- Display encoding, computed from the registered `hour`:
  - 24 h (`mode_12h` = 0): display value = `hour`.
  - 12 h (`mode_12h` = 1):
    - `hour` = 0 → 12.
    - `hour` 1–12 → `hour`.
    - `hour` 13–23 → `hour` − 12.
  - `disp_tens` = value / 10 and `disp_ones` = value % 10. Tens digit is 0 for single-digit values; no blanking.
  - `pm` = (`hour` ≥ 12).
- `mode_12h` changes only the display; it never alters `hour`.

## Timing
- `hour` and `signal_out` update on the edge that samples the request: zero added latency.
- `disp_tens`, `disp_ones` and `pm` are registered from `hour` and `mode_12h`. They lag `hour` by exactly 1 cycle.
- A `mode_12h` toggle shows on the display outputs 1 cycle later.
- `signal_out` is high for exactly one cycle, the cycle after the `signal` edge that caused the wrap.
- `signal` pulses in consecutive cycles each advance `hour` by 1. No minimum spacing is required.
- `rst` asserted mid-operation forces all outputs to reset values immediately, independent of `clk`. This includes a pending `signal_out`, which is cleared.
- First count action is on the first rising edge after `rst` deasserts.

## Test plan
- **Reset:** assert `rst` with default `RESET_HOUR` → `hour` = 0, `signal_out` = 0, `disp_tens`/`disp_ones` = 0/0, `pm` = 0. Deassert `rst` mid-cycle and check nothing changes until the next edge.
- **Rollover:** apply 24 `signal` pulses with `manual_set` = 0.
  - `hour` steps 0→23→0.
  - `signal_out` pulses exactly once, on the cycle after the 24th pulse.
  - `pm` goes 1 one cycle after `hour` reaches 12.
- **Manual setting:**
  - `manual_set` = 1, `down` at `hour` = 0 → 23, with no `signal_out`.
  - `up` at 23 → 0, with no `signal_out`.
  - `up` and `down` high together at 5 → 6.
- **Ignored inputs:**
  - `signal` during `manual_set` = 1 at `hour` = 23 → `hour` stays 23, no `signal_out`.
  - `up` with `manual_set` = 0 → no change.
- **12 h display:** `mode_12h` = 1, sweep `hour` over 0, 1, 11, 12, 13, 23.
  - Digits: 1/2, 0/1, 1/1, 1/2, 0/1, 1/1.
  - `pm`: 0, 0, 0, 1, 1, 1.
  - Each value appears one cycle after `hour` updates.
- **Reset during carry:** `signal` at `hour` = 23, then `rst` asserted before the next edge → `signal_out` stays 0 and `hour` = `RESET_HOUR`.
